// File: rtl/adc_sample_scheduler_if.sv
// adc_sample_scheduler_if: control, ADC handshake and status bundle for the sample scheduler
interface adc_sample_scheduler_if;
  logic        enable;
  logic        adc_data_valid;
  logic [15:0] adc_data_value;
  logic [15:0] thresh_hi;
  logic [15:0] thresh_lo;
  logic        fault_clear;
  logic        adc_start;
  logic [15:0] avg_value;
  logic        avg_valid;
  logic        fault_over;
  logic        fault_under;
  logic        fault_timeout;
  modport master (
    output enable, adc_data_valid, adc_data_value, thresh_hi, thresh_lo, fault_clear,
    input  adc_start, avg_value, avg_valid, fault_over, fault_under, fault_timeout
  );
  modport slave (
    input  enable, adc_data_valid, adc_data_value, thresh_hi, thresh_lo, fault_clear,
    output adc_start, avg_value, avg_valid, fault_over, fault_under, fault_timeout
  );
endinterface

// File: rtl/adc_sample_scheduler.sv
// adc_sample_scheduler: periodic ADC conversion requests, block averaging and sticky range/timeout faults
module adc_sample_scheduler #(
  parameter int SAMPLE_PERIOD  = 1000,
  parameter int AVG_LOG2       = 2,
  parameter int TIMEOUT_CYCLES = 200,
  parameter int FAULT_COUNT    = 3
) (
  input logic                   clk,
  input logic                   rst,
  adc_sample_scheduler_if.slave bus
);
  localparam int PW = $clog2(SAMPLE_PERIOD);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int FW = $clog2(FAULT_COUNT + 1);
  localparam int CW = AVG_LOG2 + 1;
  localparam int AW = 16 + AVG_LOG2;
  localparam logic [2:0] IDLE        = 3'd0;
  localparam logic [2:0] START       = 3'd1;
  localparam logic [2:0] WAIT_DATA   = 3'd2;
  localparam logic [2:0] CHECK       = 3'd3;
  localparam logic [2:0] WAIT_PERIOD = 3'd4;
  localparam logic [PW-1:0] PERIOD_LAST  = PW'(SAMPLE_PERIOD - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [FW-1:0] FAULT_SAT    = FW'(FAULT_COUNT);
  localparam logic [CW-1:0] N            = CW'(1 << AVG_LOG2);
  logic [2:0]    state, state_nx;
  logic [PW-1:0] period_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [AW-1:0] acc;
  logic [CW-1:0] cnt;
  logic [FW-1:0] over_run, under_run, over_nx, under_nx;
  logic [15:0]   avg;
  logic          sample, timed_out, period_end, clr, check;
  assign sample     = state == WAIT_DATA && bus.adc_data_valid;
  assign timed_out  = state == WAIT_DATA && !bus.adc_data_valid && tmo_cnt == TIMEOUT_LAST;
  assign period_end = state == WAIT_PERIOD && period_cnt == PERIOD_LAST;
  assign check      = state == CHECK;
  assign clr        = timed_out || check || (period_end && !bus.enable);
  assign avg        = 16'(acc >> AVG_LOG2);
  assign over_nx    = avg > bus.thresh_hi ? (over_run == FAULT_SAT ? over_run : over_run + FW'(1)) : '0;
  assign under_nx   = avg < bus.thresh_lo ? (under_run == FAULT_SAT ? under_run : under_run + FW'(1)) : '0;
  assign bus.adc_start = state == START;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:        state_nx = bus.enable ? START : IDLE;
      START:       state_nx = WAIT_DATA;
      WAIT_DATA:   state_nx = sample ? (cnt + CW'(1) == N ? CHECK : WAIT_PERIOD) : timed_out ? WAIT_PERIOD : WAIT_DATA;
      CHECK:       state_nx = WAIT_PERIOD;
      WAIT_PERIOD: state_nx = period_end ? (bus.enable ? START : IDLE) : WAIT_PERIOD;
      default:     state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      period_cnt <= '0;
      tmo_cnt    <= '0;
      acc        <= '0;
      cnt        <= '0;
    end else begin
      state      <= state_nx;
      period_cnt <= (state_nx == START || state == IDLE) ? '0 : period_cnt + PW'(1);
      tmo_cnt    <= (state_nx == START || state == IDLE) ? '0 : tmo_cnt + TW'(1);
      acc        <= sample ? acc + AW'(bus.adc_data_value) : clr ? '0 : acc;
      cnt        <= sample ? cnt + CW'(1) : clr ? '0 : cnt;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.avg_value     <= '0;
      bus.avg_valid     <= 1'b0;
      over_run          <= '0;
      under_run         <= '0;
      bus.fault_over    <= 1'b0;
      bus.fault_under   <= 1'b0;
      bus.fault_timeout <= 1'b0;
    end else begin
      bus.avg_valid     <= check;
      bus.avg_value     <= check ? avg : bus.avg_value;
      over_run          <= check ? over_nx : bus.fault_clear ? '0 : over_run;
      under_run         <= check ? under_nx : bus.fault_clear ? '0 : under_run;
      bus.fault_over    <= (check && over_nx == FAULT_SAT) || (!bus.fault_clear && bus.fault_over);
      bus.fault_under   <= (check && under_nx == FAULT_SAT) || (!bus.fault_clear && bus.fault_under);
      bus.fault_timeout <= timed_out || (!bus.fault_clear && bus.fault_timeout);
    end
  end
endmodule

// File: tb/tb_adc_sample_scheduler.sv
// tb_adc_sample_scheduler: directed scenarios with an ADC reader model and a queue-based average scoreboard
module tb_adc_sample_scheduler;
  typedef struct {
    int avg;
    int ov;
    int un;
    int tm;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int errors = 0;
  int checks = 0;
  int valid_count = 0;
  int last_valid_cyc = 0;
  bit silent = 1'b0;
  exp_t exp_q[$];
  int sample_q[$];
  int start_cyc[$];
  adc_sample_scheduler_if bus ();
  adc_sample_scheduler dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic blk(int a, int b, int c, int d, int avg, int ov, int un, int tm);
    exp_t e;
    sample_q.push_back(a);
    sample_q.push_back(b);
    sample_q.push_back(c);
    sample_q.push_back(d);
    e.avg = avg;
    e.ov = ov;
    e.un = un;
    e.tm = tm;
    exp_q.push_back(e);
  endtask
  task automatic outputs_zero(string tag);
    chk({tag, "_adc_start"}, int'(bus.adc_start), 0);
    chk({tag, "_avg_value"}, int'(bus.avg_value), 0);
    chk({tag, "_avg_valid"}, int'(bus.avg_valid), 0);
    chk({tag, "_fault_over"}, int'(bus.fault_over), 0);
    chk({tag, "_fault_under"}, int'(bus.fault_under), 0);
    chk({tag, "_fault_timeout"}, int'(bus.fault_timeout), 0);
  endtask
  task automatic do_reset(string tag);
    rst = 1'b1;
    bus.enable = 1'b0;
    bus.fault_clear = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    sample_q.delete();
    start_cyc.delete();
    outputs_zero(tag);
  endtask
  task automatic run_until_empty(string tag);
    int n = 0;
    bus.enable = 1'b1;
    while (exp_q.size() != 0 && n < 32000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_all_averages_seen"}, exp_q.size(), 0);
    bus.enable = 1'b0;
  endtask
  task automatic wait_starts(int k, int bound);
    int n = 0;
    while (start_cyc.size() < k && n < bound) begin
      @(negedge clk);
      n++;
    end
  endtask
  initial begin
    int d, v;
    bus.adc_data_valid = 1'b0;
    bus.adc_data_value = '0;
    forever begin
      @(negedge clk);
      if (bus.adc_start) begin
        d = silent ? 250 : 10;
        v = silent ? 60000 : (sample_q.size() != 0 ? sample_q.pop_front() : 0);
        repeat (d) @(negedge clk);
        bus.adc_data_value = 16'(v);
        bus.adc_data_valid = 1'b1;
        valid_count++;
        last_valid_cyc = cyc;
        @(negedge clk);
        bus.adc_data_valid = 1'b0;
      end
    end
  end
  initial forever begin
    @(negedge clk);
    if (bus.adc_start) start_cyc.push_back(cyc);
  end
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.avg_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_avg: got avg_valid with avg_value %0d, required no avg_valid (cycle %0d)", bus.avg_value, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("avg_value", int'(bus.avg_value), e.avg);
          chk("avg_fault_over", int'(bus.fault_over), e.ov);
          chk("avg_fault_under", int'(bus.fault_under), e.un);
          chk("avg_fault_timeout", int'(bus.fault_timeout), e.tm);
          chk("avg_latency", cyc - last_valid_cyc, 2);
        end
      end
    end
  end
  initial begin
    #950000;
    $display("FAIL watchdog: cycle %0d reached, required finish earlier", cyc);
    $fatal(1, "watchdog expired");
  end
  initial begin
    int s, n, vc0, c0;
    bus.thresh_hi = 16'hffff;
    bus.thresh_lo = 16'h0000;
    do_reset("por");
    blk(100, 200, 300, 400, 250, 0, 0, 0);
    run_until_empty("nominal");
    chk("nominal_start_count", start_cyc.size(), 4);
    for (int i = 1; i < 4; i++) chk("nominal_start_spacing", start_cyc.size() > i ? start_cyc[i] - start_cyc[i-1] : -1, 1000);
    do_reset("rst_after_nominal");
    bus.thresh_hi = 16'd500;
    bus.thresh_lo = 16'd300;
    blk(598, 602, 600, 600, 600, 0, 0, 0);
    blk(600, 600, 600, 601, 600, 0, 0, 0);
    blk(603, 600, 600, 600, 600, 1, 0, 0);
    blk(400, 400, 400, 400, 400, 1, 0, 0);
    blk(200, 200, 200, 200, 200, 1, 0, 0);
    blk(199, 201, 200, 200, 200, 1, 0, 0);
    blk(200, 200, 200, 200, 200, 1, 1, 0);
    run_until_empty("over_under");
    do_reset("rst_after_faults");
    bus.thresh_hi = 16'd250;
    bus.thresh_lo = 16'd250;
    blk(301, 300, 300, 302, 300, 0, 0, 0);
    blk(300, 300, 300, 300, 300, 0, 0, 0);
    blk(249, 251, 250, 250, 250, 0, 0, 0);
    blk(300, 300, 300, 300, 300, 0, 0, 0);
    run_until_empty("boundary_broken");
    do_reset("rst_after_boundary");
    bus.thresh_hi = 16'hffff;
    bus.thresh_lo = 16'h0000;
    silent = 1'b1;
    blk(10, 20, 30, 41, 25, 0, 0, 1);
    bus.enable = 1'b1;
    wait_starts(1, 20);
    s = start_cyc.size() != 0 ? start_cyc[0] : 0;
    n = 0;
    while (!bus.fault_timeout && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_set_cycle", cyc - s, 200);
    silent = 1'b0;
    wait_starts(2, 1200);
    chk("timeout_next_start", start_cyc.size() >= 2 ? start_cyc[1] - s : -1, 1000);
    run_until_empty("timeout");
    do_reset("rst_after_timeout");
    bus.thresh_hi = 16'd500;
    blk(600, 600, 600, 600, 600, 0, 0, 0);
    blk(600, 600, 600, 600, 600, 0, 0, 0);
    blk(600, 600, 600, 600, 600, 1, 0, 0);
    vc0 = valid_count;
    bus.enable = 1'b1;
    n = 0;
    while (valid_count < vc0 + 12 && n < 14000) begin
      @(negedge clk);
      n++;
    end
    while (cyc != last_valid_cyc + 1 && n < 14000) begin
      @(negedge clk);
      n++;
    end
    bus.fault_clear = 1'b1;
    @(negedge clk);
    bus.fault_clear = 1'b0;
    run_until_empty("clear_coincident");
    chk("fault_over_sticky", int'(bus.fault_over), 1);
    bus.fault_clear = 1'b1;
    @(negedge clk);
    bus.fault_clear = 1'b0;
    chk("fault_over_cleared", int'(bus.fault_over), 0);
    do_reset("rst_after_clear");
    bus.thresh_hi = 16'hffff;
    sample_q.push_back(123);
    bus.enable = 1'b1;
    wait_starts(1, 20);
    repeat (5) @(negedge clk);
    bus.enable = 1'b0;
    repeat (1500) @(negedge clk);
    chk("drop_no_more_starts", start_cyc.size(), 1);
    sample_q.push_back(7);
    bus.enable = 1'b1;
    c0 = cyc;
    repeat (2) @(negedge clk);
    bus.enable = 1'b0;
    chk("drop_restart_from_idle", start_cyc.size() >= 2 ? start_cyc[1] - c0 : -1, 1);
    repeat (20) @(negedge clk);
    do_reset("rst_after_drop");
    sample_q.push_back(11);
    sample_q.push_back(22);
    sample_q.push_back(9999);
    blk(40, 80, 120, 160, 100, 0, 0, 0);
    bus.enable = 1'b1;
    wait_starts(3, 3000);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    bus.enable = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    outputs_zero("mid_op_reset");
    repeat (30) @(negedge clk);
    start_cyc.delete();
    run_until_empty("fresh_after_reset");
    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/adc_sample_scheduler.md
ADC_SAMPLE_SCHEDULER -- requirements
Module: adc_sample_scheduler

Interface
REQ-001 The block SHALL have parameter SAMPLE_PERIOD, default 1000, clk cycles between conversion starts.
REQ-002 The block SHALL have parameter AVG_LOG2, default 2, log2 of samples averaged per block (N = 2^AVG_LOG2).
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 200, max clk cycles from adc_start to adc_data_valid.
REQ-004 The block SHALL have parameter FAULT_COUNT, default 3, consecutive out-of-range averages needed to latch a fault.
REQ-005 The block SHALL have one clock and a synchronous, active-high reset: clk  input  1  system clock; rst  input  1  synchronous active-high reset.
REQ-006 The block SHALL have the following ports, one per line:
- enable  input  1  run sampling
- adc_data_valid  input  1  one-cycle sample-ready strobe from ADC reader
- adc_data_value  input  16  sample, zero-extended 14-bit code
- thresh_hi  input  16  upper limit, unsigned
- thresh_lo  input  16  lower limit, unsigned
- fault_clear  input  1  clears sticky faults and run counters
- adc_start  output  1  one-cycle conversion request to ADC reader
- avg_value  output  16  last block average
- avg_valid  output  1  one-cycle strobe, avg_value updated
- fault_over  output  1  sticky over-threshold fault
- fault_under  output  1  sticky under-threshold fault
- fault_timeout  output  1  sticky missing-sample fault

Function
REQ-007 The block SHALL implement states IDLE, START, WAIT_DATA, CHECK, WAIT_PERIOD.
REQ-008 In IDLE with enable=1, the block SHALL go to START next cycle; with enable=0 it SHALL stay in IDLE.
REQ-009 In START, the block SHALL assert adc_start for exactly one cycle, zero the period counter and timeout counter, and go to WAIT_DATA.
REQ-010 The period counter SHALL increment every cycle outside IDLE, independent of state, so consecutive adc_start pulses are exactly SAMPLE_PERIOD cycles apart.
REQ-011 In WAIT_DATA, on adc_data_valid=1 the block SHALL add adc_data_value to a (16+AVG_LOG2)-bit accumulator and increment the sample count.
REQ-012 After that addition, the block SHALL go to CHECK if the sample count reaches N; otherwise it SHALL go to WAIT_PERIOD.
REQ-013 In WAIT_DATA, if the timeout counter reaches TIMEOUT_CYCLES-1 without adc_data_valid, the block SHALL set fault_timeout, clear the accumulator and sample count, and go to WAIT_PERIOD.
REQ-014 The block SHALL ignore adc_data_valid in every state other than WAIT_DATA.
REQ-015 In CHECK, the block SHALL register avg_value = accumulator >> AVG_LOG2 (truncating), pulse avg_valid for one cycle, clear the accumulator and sample count, and go to WAIT_PERIOD.
- Latency: avg_valid is high 2 cycles after the Nth adc_data_valid.
REQ-016 In CHECK, if avg > thresh_hi the over run counter SHALL increment (saturating at FAULT_COUNT), else reset to 0.
REQ-017 In CHECK, if avg < thresh_lo the under run counter SHALL increment (saturating at FAULT_COUNT), else reset to 0.
REQ-018 When a run counter reaches FAULT_COUNT, the matching fault flag SHALL set, aligned with avg_valid; avg equal to a threshold SHALL NOT count.
REQ-019 In WAIT_PERIOD, at period count SAMPLE_PERIOD-1 the block SHALL go to START if enable=1; if enable=0 it SHALL go to IDLE and clear the accumulator and sample count.
REQ-020 When enable falls, the block SHALL complete the current state sequence; it SHALL NOT abort WAIT_DATA or CHECK.
REQ-021 Fault flags SHALL stay set until fault_clear or rst.
REQ-022 fault_clear SHALL clear all three flags and both run counters; if a fault sets in the same cycle, the set SHALL win.
REQ-023 Integration constraint: SAMPLE_PERIOD SHALL exceed TIMEOUT_CYCLES+3; the block SHALL NOT check this.

Reset
REQ-024 On rst=1 at a clk edge, the block SHALL enter IDLE and clear all counters and the accumulator.
REQ-025 On rst=1, all outputs SHALL reset to 0: adc_start, avg_value, avg_valid, fault_over, fault_under, fault_timeout.
REQ-026 rst asserted mid-conversion SHALL abort the sequence, and an adc_data_valid arriving after reset SHALL be ignored.

Verification
REQ-027 Nominal: enable=1, ADC model returns 100,200,300,400 at 10 cycles after each adc_start -> adc_start every 1000 cycles; avg_valid once with avg_value=250, 2 cycles after 4th valid.
REQ-028 Over fault: thresh_hi=500, samples constant 600 -> fault_over set with 3rd avg_valid and not earlier; samples then 400 -> flag stays set.
REQ-029 Boundary: samples equal to thresh_lo=thresh_hi=250 -> no fault. Run broken: over, over, in-range, over -> no fault.
REQ-030 Timeout: ADC model silent after adc_start -> fault_timeout set 200 cycles after adc_start; next adc_start still at +1000; late valid ignored.
REQ-031 Clear/enable: fault_clear coincident with a 3rd over-range CHECK -> fault_over stays 1. enable dropped during WAIT_DATA -> sample accepted, no further adc_start, state returns to IDLE.
REQ-032 Reset mid-op: rst for 1 cycle in WAIT_DATA after 2 samples -> all outputs 0; after re-enable, the next average uses 4 fresh samples only.
